// File: rtl/free_list.sv
// Circular FIFO of free physical register tags for the R10K rename stage.
// Pops up to N tags to dispatch and pushes up to N retired tags per cycle. A branch checkpoint of the head can be restored.
module free_list #(
    parameter int DEPTH = 32,
    parameter int N     = 3,
    parameter int ARCH  = 32,
    localparam int TAG_W     = $clog2(ARCH + DEPTH),
    localparam int LOG_DEPTH = $clog2(DEPTH),
    localparam int PW        = LOG_DEPTH + 1,
    localparam int CW        = $clog2(N + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CW-1:0]        rd_num,
    input  logic [N*TAG_W-1:0]   wr_reg,
    input  logic [CW-1:0]        wr_num,
    input  logic                 br_en,
    input  logic [PW-1:0]        br_head,
    output logic [N*TAG_W-1:0]   free_regs,
    output logic [CW-1:0]        num_avail,
    output logic [PW-1:0]        out_head
);

    logic [TAG_W-1:0]     slots [DEPTH];
    logic [PW-1:0]        head, tail, count, space, head_next, tail_next, back_dist;
    logic [CW-1:0]        pop_num, push_num;
    logic [LOG_DEPTH-1:0] rd_idx [N];
    logic [LOG_DEPTH-1:0] wr_idx [N];

    // Pointers carry a wrap bit, so count = tail - head spans 0..DEPTH without ambiguity.
    assign count     = tail - head;
    assign space     = PW'(DEPTH) - count;
    assign back_dist = head - br_head;
    assign out_head  = head;

    // Contract: dispatch may take at most num_avail tags; retire may push at most
    // DEPTH - count tags. Anything beyond that is clamped here and flagged below.
    always_comb begin
        num_avail = (count >= PW'(N)) ? CW'(N) : CW'(count);
        pop_num   = (rd_num > num_avail) ? num_avail : rd_num;
        if (br_en) begin
            pop_num = '0;
        end
        push_num  = (PW'(wr_num) > space) ? CW'(space) : wr_num;
        head_next = br_en ? br_head : head + PW'(pop_num);
        tail_next = tail + PW'(push_num);
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            rd_idx[j] = LOG_DEPTH'(head + PW'(j));
            wr_idx[j] = LOG_DEPTH'(tail + PW'(j));
        end
    end

    always_comb begin
        free_regs = '0;
        for (int j = 0; j < N; j++) begin
            free_regs[j*TAG_W +: TAG_W] = slots[rd_idx[j]];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= PW'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= TAG_W'(ARCH + i);
            end
        end else begin
            head <= head_next;
            tail <= tail_next;
            for (int j = 0; j < N; j++) begin
                if (CW'(j) < push_num) begin
                    slots[wr_idx[j]] <= wr_reg[j*TAG_W +: TAG_W];
                end
            end
        end
    end

    // A restore target must lie between the oldest slot still holding its tag and the current head.
    a_rd_legal: assert property (@(posedge clock) disable iff (!reset)
        !br_en |-> (rd_num <= num_avail));
    a_wr_legal: assert property (@(posedge clock) disable iff (!reset)
        PW'(wr_num) <= space);
    a_br_legal: assert property (@(posedge clock) disable iff (!reset)
        br_en |-> (back_dist <= space));

endmodule
